kan_wavefront_array: RTL and testbench
======================================

// Module: kan_wavefront_array
// PURPOSE
//  KAN layer engine: ROWS x COLS grid of cells; cell (r,c) evaluates a piecewise-constant spline
//  phi_rc(x_r) from a GRID_SIZE-entry coefficient table. Column c emits y_c = sum_r phi_rc(x_r).
//  True systolic wavefront: x skewed and pipelined rightward, partial sums pipelined downward,
//  outputs deskewed. Valid/ready streaming, one vector per cycle; coefficients loaded via config port.
// PARAMETERS
//  ROWS        8   input features (array rows)
//  COLS        8   output features (array columns)
//  DATA_WIDTH  16  input sample width, unsigned offset-binary
//  COEFF_WIDTH 16  signed coefficient width
//  GRID_SIZE   8   segments per spline, power of 2; SEG_BITS=$clog2(GRID_SIZE)
//  ACC_WIDTH   COEFF_WIDTH+$clog2(ROWS)  signed column sum width, derived, never overflows
// PORTS
//  clk       in   1                  clock
//  rst_n     in   1                  async active-low reset
//  in_valid  in   1                  input vector valid
//  in_ready  out  1                  input accepted when in_valid&&in_ready
//  in_data   in   ROWS*DATA_WIDTH    x_r at [r*DATA_WIDTH +: DATA_WIDTH]
//  out_valid out  1                  output vector valid
//  out_ready in   1                  downstream accepts
//  out_data  out  COLS*ACC_WIDTH     y_c at [c*ACC_WIDTH +: ACC_WIDTH], signed
//  cfg_we    in   1                  coefficient write strobe
//  cfg_row   in   $clog2(ROWS)       target row
//  cfg_col   in   $clog2(COLS)       target column
//  cfg_seg   in   SEG_BITS           target segment
//  cfg_data  in   COEFF_WIDTH        coefficient value
//  cfg_err   out  1                  1-cycle pulse: write rejected
//  busy      out  1                  any valid token in flight or held at output
// BEHAVIOUR
//  Reset: all pipeline valids, out_valid, cfg_err, busy=0; out_data=0; every coefficient=0.
//  Segment index for x_r = x_r[DATA_WIDTH-1 -: SEG_BITS]; phi_rc = coeff[r][c][seg], sign-extended.
//  advance = !out_valid || out_ready; in_ready = advance. All stages move only when advance=1.
//  Stall: out_valid&&!out_ready freezes every stage, out_data held stable; no drop, no duplicate.
//  Bubbles are not compressed; token order preserved.
//  Skew: x_r delayed r stages before column 0; each cell registers x rightward, psum downward.
//  Deskew: column c output delayed COLS-1-c stages so all y_c of a vector appear together.
//  Latency L=ROWS+COLS cycles: vector accepted at edge t -> out_valid high after edge t+L
//  (no stall). Back-to-back accepts give back-to-back outputs, throughput 1/cycle.
//  Per-token valid bit travels with the wavefront; cells with valid=0 still shift, result ignored.
//  Config: write accepted only when busy=0 and in_valid=0 that cycle; takes effect next edge.
//  cfg_we while busy=1 or in_valid=1: write dropped, cfg_err=1 next cycle; coefficients unchanged.
//  Out-of-range cfg_row/cfg_col (non-power-of-2 sizes): dropped, cfg_err pulse.
//  busy = OR of all pipeline valid bits, including output register.
//  Async reset mid-stream: in-flight tokens discarded, coefficients cleared; in_ready=1 after
//  rst_n deasserts.
//  Sum arithmetic: signed, ACC_WIDTH, full precision; no saturation needed by construction.
// TESTING
//  1 Reset, then any vector -> out_valid after 16 cycles, all y_c=0; busy, cfg_err low at reset.
//  2 coeff[0][0][3]=100, coeff[1][0][3]=-30, x0=x1=16'h6000, rest 0 -> y0=70, y1..y7=0 at t+16.
//  3 All coeff[r][2][7]=16'h7FFF, all x=16'hFFFF -> y2=262136; coeff=16'h8000 -> y2=-262144.
//  4 20 back-to-back vectors with distinct seg patterns -> 20 consecutive outputs, in order, values match model.
//  5 out_ready low 5 cycles mid-stream -> in_ready low, out_data stable, no loss/duplicate after release.
//  6 cfg_we while busy -> cfg_err pulse, later readback vector shows old coeff.
//  7 rst_n low mid-stream -> out_valid=0 at once; after release, zero-coeff output, no stale tokens.

Source files
------------

// File: rtl/kan_wavefront_array.sv
// kan_wavefront_array: ROWS x COLS systolic KAN layer of spline cells.
// x skews rightward, partial sums flow down, column sums are deskewed.
module kan_wavefront_array #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int GRID_SIZE   = 8,
    localparam int SEG_BITS   = $clog2(GRID_SIZE),
    localparam int ACC_WIDTH  = COEFF_WIDTH + $clog2(ROWS),
    localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  out_data,
    input  logic                       cfg_we,
    input  logic [RW-1:0]              cfg_row,
    input  logic [CW-1:0]              cfg_col,
    input  logic [SEG_BITS-1:0]        cfg_seg,
    input  logic [COEFF_WIDTH-1:0]     cfg_data,
    output logic                       cfg_err,
    output logic                       busy
);
    localparam int L  = ROWS + COLS;
    localparam int XC = (COLS > 1) ? COLS - 1 : 1;

    logic                          advance;
    logic [L-1:0]                  vld_q;
    logic                          out_valid_q;
    logic                          cfg_ok;
    logic                          cfg_err_q;
    logic [COLS*ACC_WIDTH-1:0]     out_data_q;
    logic [COLS*ACC_WIDTH-1:0]     out_data_d;
    logic [DATA_WIDTH-1:0]         xin_q [ROWS];
    logic [DATA_WIDTH-1:0]         x0 [ROWS];
    logic [DATA_WIDTH-1:0]         x_in [ROWS][COLS];
    logic [DATA_WIDTH-1:0]         xh_q [ROWS][XC];
    logic signed [ACC_WIDTH-1:0]   ps_q [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]   ps_d [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]   col_out [COLS];
    logic signed [COEFF_WIDTH-1:0] coeff_q [ROWS][COLS][GRID_SIZE];

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (|vld_q) || out_valid_q;
    assign cfg_ok    = cfg_we && !busy && !in_valid &&
                       (int'(cfg_row) < ROWS) && (int'(cfg_col) < COLS);

    // Token valid chain: one bit per wavefront stage, then the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            vld_q       <= {vld_q[L-2:0], in_valid};
            out_valid_q <= vld_q[L-1];
        end
    end

    // Input sample register and deskewed output vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) xin_q[r] <= '0;
            out_data_q <= '0;
        end else if (advance) begin
            for (int r = 0; r < ROWS; r++)
                xin_q[r] <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
            out_data_q <= out_data_d;
        end
    end

    // Coefficient table writes; rejected writes raise a one-cycle error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    for (int g = 0; g < GRID_SIZE; g++)
                        coeff_q[r][c][g] <= '0;
        end else begin
            cfg_err_q <= cfg_we && !cfg_ok;
            if (cfg_ok)
                coeff_q[cfg_row][cfg_col][cfg_seg] <= cfg_data;
        end
    end

    // Cell grid: partial sums move down, x moves right, all on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) ps_q[r][c] <= '0;
                for (int c = 0; c < XC; c++) xh_q[r][c] <= '0;
            end
        end else if (advance) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) ps_q[r][c] <= ps_d[r][c];
                for (int c = 0; c < COLS - 1; c++) xh_q[r][c] <= x_in[r][c];
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        if (r == 0) begin : g_noskew
            assign x0[r] = xin_q[r];
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] sk_q [r];
            // Skew line: row r reaches column 0 r stages after capture
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < r; k++) sk_q[k] <= '0;
                end else if (advance) begin
                    sk_q[0] <= xin_q[r];
                    for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
                end
            end
            assign x0[r] = sk_q[r-1];
        end
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [SEG_BITS-1:0]         seg;
            logic signed [ACC_WIDTH-1:0] ps_in;
            if (c == 0) begin : g_xl
                assign x_in[r][c] = x0[r];
            end else begin : g_xr
                assign x_in[r][c] = xh_q[r][c-1];
            end
            if (r == 0) begin : g_top
                assign ps_in = '0;
            end else begin : g_mid
                assign ps_in = ps_q[r-1][c];
            end
            assign seg        = x_in[r][c][DATA_WIDTH-1 -: SEG_BITS];
            assign ps_d[r][c] = ps_in + ACC_WIDTH'(coeff_q[r][c][seg]);
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        localparam int N = COLS - 1 - c;
        if (N == 0) begin : g_direct
            assign col_out[c] = ps_q[ROWS-1][c];
        end else begin : g_delay
            logic signed [ACC_WIDTH-1:0] dk_q [N];
            // Deskew line: early columns wait for the last column
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < N; k++) dk_q[k] <= '0;
                end else if (advance) begin
                    dk_q[0] <= ps_q[ROWS-1][c];
                    for (int k = 1; k < N; k++) dk_q[k] <= dk_q[k-1];
                end
            end
            assign col_out[c] = dk_q[N-1];
        end
    end

    // Pack aligned column sums into the output vector
    always_comb begin
        out_data_d = '0;
        for (int c = 0; c < COLS; c++)
            out_data_d[c*ACC_WIDTH +: ACC_WIDTH] = col_out[c];
    end

endmodule

// File: tb/tb_kan_wavefront_array.sv
// tb_kan_wavefront_array: scoreboard bench for the KAN wavefront array.
// A reference model predicts each accepted vector's column sums.
module tb_kan_wavefront_array;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 16;
    localparam int G    = 8;
    localparam int SB   = 3;
    localparam int AW   = 19;
    localparam int OW   = COLS * AW;
    localparam int IW   = ROWS * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_row = '0;
    logic [2:0]    cfg_col = '0;
    logic [2:0]    cfg_seg = '0;
    logic [15:0]   cfg_data = '0;
    logic          cfg_err;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_out = 0;
    int            mcoef [ROWS][COLS][G];
    logic [OW-1:0] sbq [$];

    kan_wavefront_array dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_seg(cfg_seg), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] got,
                         input logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [IW-1:0] x);
        logic [OW-1:0] v;
        logic [SB-1:0] s;
        int            acc;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            acc = 0;
            for (int r = 0; r < ROWS; r++) begin
                s = x[r*DW+DW-1 -: SB];
                acc += mcoef[r][c][s];
            end
            v[c*AW +: AW] = acc[AW-1:0];
        end
        return v;
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 16'($urandom);
        return v;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sbq.push_back(model(in_data));
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) check("sb_extra", OW'(1), OW'(0));
                else check("sb_data", out_data, sbq.pop_front());
            end
        end
    end

    task automatic send(input logic [IW-1:0] x);
        bit acc;
        acc = 1'b0;
        in_data = x;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", OW'(0), OW'(1));
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) check("valid_timeout", OW'(0), OW'(1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || sbq.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy || sbq.size() != 0) check("drain_timeout", OW'(0), OW'(1));
    endtask

    task automatic cfg_write(input int r, input int c, input int s,
                             input logic [15:0] d, input bit ok);
        cfg_we = 1'b1;
        cfg_row = 3'(r);
        cfg_col = 3'(c);
        cfg_seg = 3'(s);
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check(ok ? "cfg_ok" : "cfg_rej", OW'(cfg_err), OW'(ok ? 0 : 1));
        if (ok) mcoef[r][c][s] = int'($signed(d));
    endtask

    initial begin
        int            k;
        int            k2;
        int            run;
        int            n0;
        logic [OW-1:0] held;
        logic [AW-1:0] e;
        logic [IW-1:0] v;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int g = 0; g < G; g++) mcoef[r][c][g] = 0;

        // 1: reset state and first-vector latency
        #12;
        check("rst_ov", OW'(out_valid), OW'(0));
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_err", OW'(cfg_err), OW'(0));
        check("rst_data", out_data, OW'(0));
        check("rst_inrdy", OW'(in_ready), OW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(rand_vec());
        wait_valid(k);
        check("t1_latency", OW'(k), OW'(16));
        check("t1_zero", out_data, OW'(0));
        drain();

        // 2: two-row sum into column 0
        cfg_write(0, 0, 3, 16'd100, 1'b1);
        cfg_write(1, 0, 3, 16'hFFE2, 1'b1);
        v = '0;
        v[0*DW +: DW] = 16'h6000;
        v[1*DW +: DW] = 16'h6000;
        send(v);
        wait_valid(k);
        e = AW'(70);
        check("t2_y0", OW'(out_data[0*AW +: AW]), OW'(e));
        check("t2_y1", OW'(out_data[1*AW +: AW]), OW'(0));
        drain();

        // 3: full-scale positive and negative column sums
        for (int r = 0; r < ROWS; r++) cfg_write(r, 2, 7, 16'h7FFF, 1'b1);
        send({IW{1'b1}});
        wait_valid(k);
        e = AW'(262136);
        check("t3_pos", OW'(out_data[2*AW +: AW]), OW'(e));
        drain();
        for (int r = 0; r < ROWS; r++) cfg_write(r, 2, 7, 16'h8000, 1'b1);
        send({IW{1'b1}});
        wait_valid(k);
        e = AW'(-262144);
        check("t3_neg", OW'(out_data[2*AW +: AW]), OW'(e));
        drain();

        // 4: random table, 20 back-to-back vectors
        for (int i = 0; i < 48; i++)
            cfg_write($urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), 16'($urandom), 1'b1);
        n0 = n_out;
        run = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(rand_vec());
            end
            begin
                wait_valid(k2);
                for (int i = 0; i < 20; i++) begin
                    if (out_valid) run++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        check("t4_b2b", OW'(run), OW'(20));
        drain();
        check("t4_count", OW'(n_out - n0), OW'(20));

        // 5: five-cycle downstream stall mid-stream
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 24; i++) send(rand_vec());
            end
            begin
                wait_valid(k2);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) begin
                        held = out_data;
                        check("t5_ov", OW'(out_valid), OW'(1));
                    end
                    check("t5_inrdy", OW'(in_ready), OW'(0));
                    check("t5_hold", out_data, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("t5_count", OW'(n_out - n0), OW'(24));

        // 6: writes rejected while busy or while in_valid is high
        cfg_write(0, 0, 0, 16'd1234, 1'b1);
        send('0);
        cfg_write(0, 0, 0, 16'd555, 1'b0);
        @(posedge clk);
        #1;
        check("t6_pulse", OW'(cfg_err), OW'(0));
        drain();
        in_data = '0;
        in_valid = 1'b1;
        cfg_we = 1'b1;
        cfg_row = 3'd0;
        cfg_col = 3'd0;
        cfg_seg = 3'd0;
        cfg_data = 16'd777;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        check("t6_inval_err", OW'(cfg_err), OW'(1));
        drain();
        send('0);
        drain();

        // 7: asynchronous reset while tokens are in flight
        for (int i = 0; i < 6; i++) send(rand_vec());
        wait_valid(k);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_ov", OW'(out_valid), OW'(0));
        check("t7_busy", OW'(busy), OW'(0));
        sbq.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int g = 0; g < G; g++) mcoef[r][c][g] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t7_inrdy", OW'(in_ready), OW'(1));
        @(posedge clk);
        #1;
        n0 = n_out;
        send(rand_vec());
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("t7_count", OW'(n_out - n0), OW'(1));
        check("sb_left", OW'(sbq.size()), OW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
